// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants, state encoding and CRC32 byte step for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam logic [7:0]  HdrPad        = 8'h00;
  localparam int unsigned FrameOverhead = 8;

  localparam logic [7:0] MsgInfo       = 8'h00;
  localparam logic [7:0] MsgInvalid    = 8'h01;
  localparam logic [7:0] MsgPong       = 8'h02;
  localparam logic [7:0] MsgResend     = 8'h03;
  localparam logic [7:0] MsgNonceFound = 8'h04;

  // Reflected CRC32 with no final inversion, so a frame plus its LSB-first trailer checks to 0.
  localparam logic [31:0] CrcPoly = 32'hEDB8_8320;
  localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;

  typedef enum logic [4:0] {
    StIdle    = 5'b00001,
    StHeader  = 5'b00010,
    StPayload = 5'b00100,
    StCrcWait = 5'b01000,
    StCrc     = 5'b10000
  } tx_state_e;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_crc32.sv
// Byte-wide CRC32 accumulator; clear restarts it at the start of each frame.
module uart_tx_arbiter_crc32
  import uart_tx_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        rx_we,
  input  logic [7:0]  rx_byte,
  output logic [31:0] tx_crc
);

  logic [31:0] crc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= CrcInit;
    end else if (clear) begin
      crc_q <= CrcInit;
    end else if (rx_we) begin
      crc_q <= crc32_byte(crc_q, rx_byte);
    end
  end

  assign tx_crc = crc_q;

endmodule

// File: rtl/uart_tx_arbiter_rr_grant.sv
// Combinational round-robin pick: first request scanning upward from last+1.
module uart_tx_arbiter_rr_grant #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int off = int'(NUM_REQ); off > 0; off--) begin
      idx = (int'(last) + off) % int'(NUM_REQ);
      if (req[idx]) begin
        gnt       = '0;
        gnt[idx]  = 1'b1;
        gnt_idx   = IDX_W'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter serialising source messages into length/header/payload/CRC32 frames.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned MAX_PAYLOAD = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*8-1:0]           req_type,
  input  logic [NUM_REQ*4-1:0]           req_len,
  input  logic [NUM_REQ*MAX_PAYLOAD*8-1:0] req_payload,
  output logic [NUM_REQ-1:0]             req_ack,
  input  logic                           fifo_full,
  output logic                           tx_we,
  output logic [7:0]                     tx_data,
  output logic                           busy
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PayW   = MAX_PAYLOAD * 8;
  localparam logic [3:0]  MaxLen = 4'(MAX_PAYLOAD);

  tx_state_e          state_q, state_d;
  logic [1:0]         hdr_cnt_q, hdr_cnt_d;
  logic [1:0]         crc_cnt_q, crc_cnt_d;
  logic [3:0]         pay_cnt_q, pay_cnt_d;
  logic [3:0]         len_q, len_d;
  logic [7:0]         type_q, type_d;
  logic [PayW-1:0]    shift_q, shift_d;
  logic [31:0]        crc_q, crc_d;
  logic [IdxW-1:0]    gnt_q, gnt_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IdxW-1:0]    gnt_idx;
  logic               gnt_valid;
  logic               crc_clear, crc_we;
  logic [31:0]        tx_crc;
  logic [7:0]         sel_type;
  logic [3:0]         sel_len;
  logic [PayW-1:0]    sel_payload;

  uart_tx_arbiter_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_grant (
    .req       (req_valid),
    .last      (last_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  uart_tx_arbiter_crc32 u_crc32 (
    .clk     (clk),
    .reset   (reset),
    .clear   (crc_clear),
    .rx_we   (crc_we),
    .rx_byte (tx_data),
    .tx_crc  (tx_crc)
  );

  always_comb begin
    sel_type    = '0;
    sel_len     = '0;
    sel_payload = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        sel_type    |= req_type[i*8 +: 8];
        sel_len     |= req_len[i*4 +: 4];
        sel_payload |= req_payload[i*PayW +: PayW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    crc_cnt_d = crc_cnt_q;
    pay_cnt_d = pay_cnt_q;
    len_d     = len_q;
    type_d    = type_q;
    shift_d   = shift_q;
    crc_d     = crc_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    ack_d     = '0;
    tx_we     = 1'b0;
    tx_data   = 8'h00;
    crc_clear = 1'b0;
    crc_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          type_d    = sel_type;
          len_d     = (sel_len > MaxLen) ? MaxLen : sel_len;
          shift_d   = sel_payload;
          gnt_d     = gnt_idx;
          ack_d     = gnt;
          hdr_cnt_d = '0;
          crc_clear = 1'b1;
          state_d   = StHeader;
        end
      end
      StHeader: begin
        case (hdr_cnt_q)
          2'd0:    tx_data = 8'(FrameOverhead) + 8'(len_q);
          2'd3:    tx_data = type_q;
          default: tx_data = HdrPad;
        endcase
        if (!fifo_full) begin
          tx_we     = 1'b1;
          crc_we    = 1'b1;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            pay_cnt_d = len_q;
            state_d   = (len_q != '0) ? StPayload : StCrcWait;
          end
        end
      end
      StPayload: begin
        tx_data = shift_q[7:0];
        if (!fifo_full) begin
          tx_we     = 1'b1;
          crc_we    = 1'b1;
          shift_d   = shift_q >> 8;
          pay_cnt_d = pay_cnt_q - 4'd1;
          if (pay_cnt_q == 4'd1) state_d = StCrcWait;
        end
      end
      StCrcWait: begin
        // Last CRC input byte landed on the previous edge; snapshot the result.
        crc_d     = tx_crc;
        crc_cnt_d = '0;
        state_d   = StCrc;
      end
      StCrc: begin
        tx_data = crc_q[7:0];
        if (!fifo_full) begin
          tx_we     = 1'b1;
          crc_d     = crc_q >> 8;
          crc_cnt_d = crc_cnt_q + 2'd1;
          if (crc_cnt_q == 2'd3) begin
            last_d  = gnt_q;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      hdr_cnt_q <= '0;
      crc_cnt_q <= '0;
      pay_cnt_q <= '0;
      len_q     <= '0;
      type_q    <= '0;
      shift_q   <= '0;
      crc_q     <= '0;
      gnt_q     <= '0;
      last_q    <= IdxW'(NUM_REQ - 1);
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      crc_cnt_q <= crc_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      len_q     <= len_d;
      type_q    <= type_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
    end
  end

  assign req_ack = ack_q;
  assign busy    = (state_q != StIdle);

endmodule
